// File: rtl/trace_event_counters_if.sv
// Register access bus for the trace event counter bank.
// One request per cycle; reads answer exactly one cycle later.
interface trace_event_counters_if;
    logic        reg_valid;
    logic        reg_write;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_rvalid;
    logic [31:0] reg_rdata;

    modport master (
        output reg_valid, reg_write, reg_addr, reg_wdata,
        input  reg_rvalid, reg_rdata
    );

    modport slave (
        input  reg_valid, reg_write, reg_addr, reg_wdata,
        output reg_rvalid, reg_rdata
    );
endinterface

// File: rtl/trace_event_counters.sv
// Performance counter bank fed by the core's per-cycle trace event vector.
// Software access is through a registered word port with sticky overflow flags.
module trace_event_counters #(
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // Packed event vector: bit 0 = br_is_call, bit 32 = early_branch_correction.
    input  logic [32:0]            events_i,
    trace_event_counters_if.slave  bus,
    output logic                   overflow_irq
);
    localparam int unsigned N  = NUM_COUNTERS;
    localparam int unsigned W  = COUNTER_WIDTH;
    localparam int unsigned HW = W - 32;

    logic [32:0]   ev_q;
    logic [W-1:0]  cnt_q [N];
    logic [W-1:0]  cnt_d [N];
    logic [5:0]    sel_q [N];
    logic [5:0]    sel_d [N];
    logic [N-1:0]  en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic          freeze_q, freeze_d;
    logic [HW-1:0] shadow_q, shadow_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          wr, rd, clear_all, acc_cnt, hit;
    logic [3:0]    acc_idx;
    logic [1:0]    acc_sub;
    logic [63:0]   ev_ext;
    logic [31:0]   hi_rd;

    always_comb begin
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        freeze_d  = freeze_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;
        hit       = 1'b0;
        hi_rd     = '0;
        hi_rd[HW-1:0] = shadow_q;

        wr        = bus.reg_valid & bus.reg_write;
        rd        = bus.reg_valid & ~bus.reg_write;
        rvalid_d  = rd;
        // Word 4+4k..7+4k belong to counter k; sub-word 3 is a hole.
        acc_idx   = bus.reg_addr[5:2] - 4'd1;
        acc_sub   = bus.reg_addr[1:0];
        acc_cnt   = bus.reg_addr[5:2] != 4'd0;
        clear_all = wr && bus.reg_addr == 6'd0 && bus.reg_wdata[1];
        // Selects above 32 land in the zero-padded upper half.
        ev_ext    = {31'b0, ev_q};

        if (wr && bus.reg_addr == 6'd0) freeze_d = bus.reg_wdata[0];
        if (wr && bus.reg_addr == 6'd1) ovf_d = ovf_q & ~bus.reg_wdata[N-1:0];

        if (rd) begin
            rdata_d = '0;
            if (bus.reg_addr == 6'd0) rdata_d[0] = freeze_q;
            if (bus.reg_addr == 6'd1) rdata_d[N-1:0] = ovf_q;
        end

        for (int k = 0; k < N; k++) begin
            logic match;
            match = acc_cnt && acc_idx == 4'(k);
            hit   = en_q[k] & ~freeze_q & ev_ext[sel_q[k]];

            if (rd && match) begin
                case (acc_sub)
                    2'd0: rdata_d = {22'b0, irq_en_q[k], en_q[k], 2'b0, sel_q[k]};
                    2'd1: begin
                        rdata_d  = cnt_q[k][31:0];
                        shadow_d = cnt_q[k][W-1:32];
                    end
                    2'd2: rdata_d = hi_rd;
                    default: rdata_d = '0;
                endcase
            end

            if (wr && match && acc_sub == 2'd0) begin
                sel_d[k]    = bus.reg_wdata[5:0];
                en_d[k]     = bus.reg_wdata[8];
                irq_en_d[k] = bus.reg_wdata[9];
            end

            // Wrap sets the flag after the W1C above, so set wins.
            if (clear_all) begin
                cnt_d[k] = '0;
            end else if (wr && match && acc_sub == 2'd1) begin
                cnt_d[k][31:0] = bus.reg_wdata;
            end else if (wr && match && acc_sub == 2'd2) begin
                cnt_d[k][W-1:32] = bus.reg_wdata[HW-1:0];
            end else if (hit) begin
                cnt_d[k] = cnt_q[k] + W'(1);
                if (&cnt_q[k]) ovf_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_q     <= '0;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
                sel_q[k] <= '0;
            end
            en_q     <= '0;
            irq_en_q <= '0;
            ovf_q    <= '0;
            freeze_q <= 1'b0;
            shadow_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ev_q     <= events_i;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            freeze_q <= freeze_d;
            shadow_q <= shadow_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.reg_rvalid = rvalid_q;
    assign bus.reg_rdata  = rdata_q;
    assign overflow_irq   = |(ovf_q & irq_en_q);

endmodule

// File: tb/tb_trace_event_counters.sv
// Directed bench for trace_event_counters: a register-access vector table
// followed by hand-written multi-cycle sequences for counting corner cases.
module tb_trace_event_counters;
    localparam logic [32:0] EvEbc = 33'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] events;
    logic        irq;
    int          nvec  = 0;
    int          nfail = 0;

    trace_event_counters_if bus_if ();

    trace_event_counters #(
        .NUM_COUNTERS (4),
        .COUNTER_WIDTH(48)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .events_i    (events),
        .bus         (bus_if.slave),
        .overflow_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;  // write data, or expected read data
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus_if.reg_valid = 1'b1;
        bus_if.reg_write = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        tick();
        bus_if.reg_valid = 1'b0;
        bus_if.reg_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
        bus_if.reg_valid = 1'b1;
        bus_if.reg_write = 1'b0;
        bus_if.reg_addr  = a;
        tick();
        bus_if.reg_valid = 1'b0;
        check({name, " rvalid"}, 32'(bus_if.reg_rvalid), 32'd1);
        check(name, bus_if.reg_rdata, exp);
    endtask

    initial begin
        bus_if.reg_valid = 1'b0;
        bus_if.reg_write = 1'b0;
        bus_if.reg_addr  = '0;
        bus_if.reg_wdata = '0;
        events = '0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset irq", 32'(irq), 32'd0);
        check("reset rvalid", 32'(bus_if.reg_rvalid), 32'd0);

        // Reset state, CFG field masking and unmapped addresses.
        tbl.push_back('{1'b0, 6'd0,  32'h0,          "rst gctrl"});
        tbl.push_back('{1'b0, 6'd1,  32'h0,          "rst ovf"});
        tbl.push_back('{1'b0, 6'd4,  32'h0,          "rst cfg0"});
        tbl.push_back('{1'b0, 6'd5,  32'h0,          "rst lo0"});
        tbl.push_back('{1'b0, 6'd6,  32'h0,          "rst hi0"});
        tbl.push_back('{1'b1, 6'd16, 32'hFFFF_FFFF, "wr cfg3"});
        tbl.push_back('{1'b0, 6'd16, 32'h0000_033F, "cfg3 mask"});
        tbl.push_back('{1'b1, 6'd16, 32'h0,          "clr cfg3"});
        tbl.push_back('{1'b0, 6'd16, 32'h0,          "cfg3 zero"});
        tbl.push_back('{1'b1, 6'd2,  32'hFFFF_FFFF, "wr gap2"});
        tbl.push_back('{1'b0, 6'd2,  32'h0,          "rd gap2"});
        tbl.push_back('{1'b0, 6'd3,  32'h0,          "rd gap3"});
        tbl.push_back('{1'b0, 6'd7,  32'h0,          "rd gap7"});
        tbl.push_back('{1'b1, 6'd20, 32'hFFFF_FFFF, "wr cfg4 oob"});
        tbl.push_back('{1'b0, 6'd20, 32'h0,          "rd cfg4 oob"});
        tbl.push_back('{1'b0, 6'd21, 32'h0,          "rd lo4 oob"});

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                wr(tbl[i].addr, tbl[i].data);
                check({tbl[i].name, " no resp"}, 32'(bus_if.reg_rvalid), 32'd0);
            end else begin
                rd(tbl[i].addr, tbl[i].data, tbl[i].name);
            end
        end
        check("tbl irq", 32'(irq), 32'd0);

        // Basic counting with the two-cycle latency, then freeze.
        wr(6'd4, 32'h0000_0120);
        events = EvEbc;
        repeat (10) tick();
        events = '0;
        tick();
        tick();
        rd(6'd5, 32'd10, "cnt lo0");
        rd(6'd6, 32'd0, "cnt hi0");
        wr(6'd0, 32'd1);
        rd(6'd0, 32'd1, "freeze rd");
        events = EvEbc;
        repeat (5) tick();
        events = '0;
        tick();
        tick();
        rd(6'd5, 32'd10, "frozen lo0");
        wr(6'd0, 32'd0);

        // Wrap to zero sets the sticky flag; irq follows the flag.
        wr(6'd6, 32'h0000_FFFF);
        wr(6'd5, 32'hFFFF_FFFE);
        wr(6'd4, 32'h0000_0320);
        events = EvEbc;
        tick();
        tick();
        check("irq before wrap", 32'(irq), 32'd0);
        events = '0;
        tick();
        check("irq after wrap", 32'(irq), 32'd1);
        rd(6'd1, 32'd1, "ovf set");
        rd(6'd5, 32'd0, "wrap lo0");
        rd(6'd6, 32'd0, "wrap hi0");
        wr(6'd1, 32'd1);
        check("irq after w1c", 32'(irq), 32'd0);
        rd(6'd1, 32'd0, "ovf cleared");
        wr(6'd6, 32'h0000_FFFF);
        wr(6'd5, 32'hFFFF_FFFF);
        events = EvEbc;
        tick();
        events = '0;
        wr(6'd1, 32'd1);
        rd(6'd1, 32'd1, "set beats w1c");
        check("irq set beats w1c", 32'(irq), 32'd1);

        // HI reads return the shadow captured by the preceding LO read.
        events = EvEbc;
        wr(6'd6, 32'd0);
        wr(6'd5, 32'hFFFF_FFFF);
        rd(6'd5, 32'hFFFF_FFFF, "atomic lo");
        tick();
        rd(6'd6, 32'd0, "atomic hi shadow");
        events = '0;
        tick();
        rd(6'd5, 32'd3, "live lo");
        rd(6'd6, 32'd1, "live hi");

        // Software write and clear_all both beat a concurrent increment.
        wr(6'd8, 32'h0000_0100);
        events = 33'h1;
        tick();
        events = '0;
        wr(6'd9, 32'h0000_0100);
        tick();
        rd(6'd9, 32'h0000_0100, "write beats inc");
        events = 33'h1 | EvEbc;
        tick();
        events = '0;
        wr(6'd0, 32'd2);
        tick();
        rd(6'd9, 32'd0, "clear lo1");
        rd(6'd5, 32'd0, "clear lo0");
        rd(6'd6, 32'd0, "clear hi0");
        rd(6'd1, 32'd1, "clear keeps ovf");
        rd(6'd8, 32'h0000_0100, "clear keeps cfg1");
        rd(6'd0, 32'd0, "clear_all reads 0");

        // Out-of-range select counts nothing even with every event high.
        wr(6'd12, 32'h0000_0128);
        events = {33{1'b1}};
        repeat (5) tick();
        events = '0;
        tick();
        tick();
        rd(6'd13, 32'd0, "sel40 lo2");
        rd(6'd9, 32'd5, "sel0 lo1");
        rd(6'd12, 32'h0000_0128, "cfg2 rd");
        tick();
        check("rvalid drops", 32'(bus_if.reg_rvalid), 32'd0);
        check("rdata holds", bus_if.reg_rdata, 32'h0000_0128);

        // Reset in the same cycle as a read drops the response.
        bus_if.reg_valid = 1'b1;
        bus_if.reg_write = 1'b0;
        bus_if.reg_addr  = 6'd9;
        rst_n = 1'b0;
        tick();
        bus_if.reg_valid = 1'b0;
        rst_n = 1'b1;
        check("reset drops read", 32'(bus_if.reg_rvalid), 32'd0);
        check("reset rdata", bus_if.reg_rdata, 32'd0);
        check("reset irq 2", 32'(irq), 32'd0);
        rd(6'd9, 32'd0, "post-rst lo1");
        rd(6'd1, 32'd0, "post-rst ovf");
        rd(6'd8, 32'd0, "post-rst cfg1");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/trace_event_counters.md
Name: trace_event_counters

Overview:
- Consumer side of the core trace-event interface: samples the per-cycle cva5_trace_events_t vector emitted by the core and accumulates selected events into a bank of programmable hardware performance counters.
- Software reaches it through a simple registered word-access port with sticky overflow flags and an overflow interrupt.
- Sits beside the CSR/peripheral space.
- The core only generates events; this block counts them.

Parameters:
- NUM_COUNTERS, 4: number of counters; legal range 1..15.
- COUNTER_WIDTH, 48: counter width in bits; legal range 33..64.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- events_i  in  cva5_trace_events_t (33)  per-cycle event pulses from the core
- reg_valid  in  1  access request, single-cycle
- reg_write  in  1  1 = write, 0 = read
- reg_addr  in  6  word address
- reg_wdata  in  32  write data
- reg_rvalid  out  1  read data valid
- reg_rdata  out  32  read data
- overflow_irq  out  1  OR over counters of (ovf & irq_en)

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n low on a clk rising edge).
  - All counters, CFG, freeze, ovf flags, the HI shadow register and the event pipeline register clear to 0.
  - reg_rvalid=0, reg_rdata=0, overflow_irq=0.
  - A reset asserted mid-access drops the access; no response is returned.
- Event pipeline: events_i is registered once (ev_q).
  - Event select index s refers to packed bit s of cva5_trace_events_t: 0 = br_is_call (LSB), 32 = early_branch_correction (MSB).
  - s >= 33 selects constant 0.
- Increment: counter k increments by 1 at edge t+2 if:
  - its event bit was high in cycle t (registered at edge t+1), and
  - CFG.enable=1, and
  - freeze=0.
  - There is at most +1 per cycle.
- Address map (word address):
  - 0 GCTRL: bit0 freeze (R/W); bit1 clear_all (write-1 pulse, reads 0).
  - 1 OVF: bits[N-1:0] sticky overflow flags; write-1-to-clear.
  - 4+4k CFG_k: [5:0] select, [8] enable, [9] irq_en; other bits read 0.
  - 5+4k LO_k: counter bits[31:0].
  - 6+4k HI_k: counter bits[W-1:32], zero-extended.
  - Any other address: reads 0, writes ignored. This includes the gaps, 2–3, 7+4k, and counters >= N.
- Reads:
  - reg_rvalid pulses exactly 1 cycle after a read request, with reg_rdata registered.
  - reg_rdata holds its value until the next read response.
  - Writes produce no response.
  - Back-to-back accesses are accepted every cycle.
- Atomic 64-bit read: reading LO_k latches counter bits[W-1:32] into the shared HI shadow in the same edge. Reading any HI_k returns the shadow, not the live value.
- Writes: LO_k and HI_k writes replace the corresponding bits of the counter.
- Overflow: an increment from all-ones wraps to 0 and sets ovf[k].
- Priorities, highest first, for the same counter in the same cycle:
  - rst_n
  - clear_all (zeroes all counters; flags and CFG unchanged)
  - software LO/HI write (the concurrent increment is lost; the write does not set ovf)
  - increment
- Flag set and clear: if ovf is set by a wrap in the same cycle as a W1C clear of that bit, set wins.
- overflow_irq is combinational from registered state, so it rises the cycle after the flag sets.
- Freeze: blocks increments only; software writes still apply. Events arriving while frozen are discarded, not deferred.

Test Plan:
1. Reset, then read addrs 0, 1, 4, 5, 6 → reg_rvalid one cycle after each request, all data 0, overflow_irq=0.
2. CFG_0 = select 32, enable; drive early_branch_correction high 10 consecutive cycles → LO_0 reads 10 and HI_0 reads 0, counting the 2-cycle latency; with freeze=1 during 5 further pulses, LO_0 stays 10.
3. HI_0 = 0xFFFF, LO_0 = 0xFFFFFFFE, irq_en=1; two events → counter wraps to 0 and ovf[0]=1; overflow_irq rises the next cycle; W1C OVF=1 in the same cycle as a new wrap → flag stays 1.
4. Atomic read: counter = 0x0000_FFFF_FFFF; event every cycle; read LO, then HI two cycles later → LO=0xFFFFFFFF, HI=0 (shadow), although the live HI is 1.
5. Simultaneous write LO_1=0x100 with a counted event in the same cycle → readback 0x100; clear_all together with an event → all counters 0.
6. Select 40 (>32) with enable set and all events high → counter stays 0; reads of addr 3 and addr 4+4*NUM_COUNTERS return 0.
